// File: rtl/piano_key_scan.sv
// Key scanner: synchronises and debounces NUM_KEYS switch inputs, derives per-note enables in one of
// four play modes, and queues press/release events behind a valid/ready handshake.
module piano_key_scan #(
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IDX_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic [1:0]          mode,
  output logic [NUM_KEYS-1:0] en,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [IDX_W-1:0]    event_key,
  output logic                event_press,
  output logic                overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_POLY   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_LAST   = 2'b10,
    MODE_LOW    = 2'b11
  } mode_t;

  logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_stable, r_stable_d;
  logic [CNT_W-1:0]    r_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_latch;
  logic [1:0]          r_mode;
  logic                r_cur_valid;
  logic [IDX_W-1:0]    r_cur;
  logic [NUM_KEYS-1:0] r_pend_press, r_pend_rel;

  logic [NUM_KEYS-1:0] w_press, w_rel;
  logic                w_mode_chg;
  logic [NUM_KEYS-1:0] w_latch_next;
  logic [IDX_W-1:0]    w_hi_press, w_hi_held, w_lo_held;
  logic                w_lo_found;
  logic                w_cur_valid_next;
  logic [IDX_W-1:0]    w_cur_next;
  logic [NUM_KEYS-1:0] w_en_next;
  logic                w_sel_found, w_sel_press, w_load;
  logic [IDX_W-1:0]    w_sel_key;
  logic [NUM_KEYS-1:0] w_clr_press, w_clr_rel;
  logic [NUM_KEYS-1:0] w_pend_press_next, w_pend_rel_next;
  logic                w_overrun_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1    <= sw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (r_sync2[k] != r_stable[k]) begin
          if (r_cnt[k] == CNT_LAST) begin
            r_stable[k] <= ~r_stable[k];
            r_cnt[k]    <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  assign w_press    = r_stable & ~r_stable_d;
  assign w_rel      = ~r_stable & r_stable_d;
  assign w_mode_chg = (mode != r_mode);

  always_comb begin
    w_hi_press = '0;
    w_hi_held  = '0;
    w_lo_held  = '0;
    w_lo_found = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (w_press[k])  w_hi_press = IDX_W'(k);
      if (r_stable[k]) w_hi_held  = IDX_W'(k);
      if (r_stable[k] && !w_lo_found) begin
        w_lo_held  = IDX_W'(k);
        w_lo_found = 1'b1;
      end
    end

    // A mode change wipes latch/current-key state before this cycle's strobes are applied
    w_latch_next = (w_mode_chg ? '0 : r_latch) ^ w_press;

    w_cur_valid_next = 1'b0;
    w_cur_next       = '0;
    if (|w_press) begin
      w_cur_valid_next = 1'b1;
      w_cur_next       = w_hi_press;
    end else if (r_cur_valid && !w_mode_chg && r_stable[r_cur]) begin
      w_cur_valid_next = 1'b1;
      w_cur_next       = r_cur;
    end else if (|r_stable) begin
      w_cur_valid_next = 1'b1;
      w_cur_next       = w_hi_held;
    end

    w_en_next = '0;
    case (mode_t'(mode))
      MODE_POLY:   w_en_next = r_stable;
      MODE_TOGGLE: w_en_next = w_latch_next;
      MODE_LAST:   if (w_cur_valid_next) w_en_next[w_cur_next] = 1'b1;
      MODE_LOW:    if (w_lo_found) w_en_next[w_lo_held] = 1'b1;
      default:     w_en_next = '0;
    endcase
  end

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_key   = '0;
    w_sel_press = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (!w_sel_found && (r_pend_press[k] || r_pend_rel[k])) begin
        w_sel_found = 1'b1;
        w_sel_key   = IDX_W'(k);
        w_sel_press = r_pend_press[k];
      end
    end

    w_load      = w_sel_found && (!event_valid || event_ready);
    w_clr_press = '0;
    w_clr_rel   = '0;
    if (w_load) begin
      if (w_sel_press) w_clr_press[w_sel_key] = 1'b1;
      else             w_clr_rel[w_sel_key]   = 1'b1;
    end

    // A strobe landing on a bit being serviced this edge re-arms it rather than overrunning
    w_pend_press_next = (r_pend_press & ~w_clr_press) | w_press;
    w_pend_rel_next   = (r_pend_rel & ~w_clr_rel) | w_rel;
    w_overrun_set     = |(w_press & r_pend_press & ~w_clr_press) |
                        |(w_rel & r_pend_rel & ~w_clr_rel);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch      <= '0;
      r_mode       <= '0;
      r_cur_valid  <= 1'b0;
      r_cur        <= '0;
      en           <= '0;
      r_pend_press <= '0;
      r_pend_rel   <= '0;
      event_valid  <= 1'b0;
      event_key    <= '0;
      event_press  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_latch      <= w_latch_next;
      r_mode       <= mode;
      r_cur_valid  <= w_cur_valid_next;
      r_cur        <= w_cur_next;
      en           <= w_en_next;
      r_pend_press <= w_pend_press_next;
      r_pend_rel   <= w_pend_rel_next;
      if (w_overrun_set) overrun <= 1'b1;
      if (w_load) begin
        event_valid <= 1'b1;
        event_key   <= w_sel_key;
        event_press <= w_sel_press;
      end else if (event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piano_key_scan.sv
// Bench for piano_key_scan: directed latency/glitch/queue/overrun/reset scenarios plus random
// key/mode steps checked against a step-level behavioural model and an event scoreboard.
module tb_piano_key_scan;

  localparam int NK = 8;
  localparam int DC = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] sw = '0;
  logic [1:0]    mode = '0;
  logic [NK-1:0] en;
  logic          event_valid;
  logic          event_ready = 1'b0;
  logic [IW-1:0] event_key;
  logic          event_press;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  int mdl_sw, mdl_latch, mdl_cur, mdl_mode, mdl_en;
  int exp_q[$];
  int got_q[$];

  piano_key_scan #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .mode(mode), .en(en),
    .event_valid(event_valid), .event_ready(event_ready), .event_key(event_key),
    .event_press(event_press), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Handshake seen at the negedge is the one taken on the following posedge.
  always @(negedge clk)
    if (reset_n && event_valid && event_ready) got_q.push_back(int'(event_key) * 2 + int'(event_press));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    mdl_sw = 0; mdl_latch = 0; mdl_cur = -1; mdl_mode = 0; mdl_en = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic model_apply(input int s, input int m);
    int pr, rl;
    if (m != mdl_mode) begin
      mdl_latch = 0;
      mdl_cur   = -1;
      mdl_mode  = m;
    end
    pr = s & ~mdl_sw & 8'hFF;
    rl = mdl_sw & ~s & 8'hFF;
    mdl_latch = mdl_latch ^ pr;
    for (int k = 0; k < NK; k++) begin
      if (pr[k]) exp_q.push_back(k * 2 + 1);
      if (rl[k]) exp_q.push_back(k * 2);
    end
    if (pr != 0) mdl_cur = $clog2(pr + 1) - 1;
    else if (mdl_cur < 0 || !s[mdl_cur]) mdl_cur = (s == 0) ? -1 : $clog2(s + 1) - 1;
    mdl_sw = s;
    case (m)
      0: mdl_en = s;
      1: mdl_en = mdl_latch;
      2: mdl_en = (mdl_cur < 0) ? 0 : (1 << mdl_cur);
      default: mdl_en = s & -s;
    endcase
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_evcount"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_event"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic apply(input int s, input int m, input string tag);
    model_apply(s, m);
    sw = NK'(s);
    mode = 2'(m);
    repeat (60) begin @(posedge clk); #1; event_ready = ($urandom_range(0, 3) != 0); end
    event_ready = 1'b1;
    cyc(10);
    event_ready = 1'b0;
    check({tag, "_en"}, en, mdl_en);
    check({tag, "_valid"}, event_valid, 0);
    compare_events(tag);
  endtask

  task automatic hold_noready(input int s);
    model_apply(s, mdl_mode);
    sw = NK'(s);
    cyc(12);
  endtask

  initial begin
    model_reset();
    cyc(3);
    check("rst_en", en, 0);
    check("rst_valid", event_valid, 0);
    check("rst_key", event_key, 0);
    check("rst_press", event_press, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    cyc(2);

    // Latency: first sampling edge counted as edge 1, en rises on edge 3+DC.
    sw = 8'h01;
    cyc(3 + DC - 1);
    check("lat_before", en[0], 0);
    cyc(1);
    check("lat_en", en[0], 1);
    cyc(1);
    check("lat_valid", event_valid, 1);
    check("lat_key", event_key, 0);
    check("lat_press", event_press, 1);
    model_apply(8'h01, 0);

    sw = 8'h00;
    cyc(DC - 1);
    sw = 8'h01;
    cyc(20);
    check("glitch_en", en, 8'h01);
    apply(8'h01, 0, "glitch");
    apply(8'h00, 0, "rel0");

    apply(8'h04, 1, "tog_p1");
    apply(8'h00, 1, "tog_r1");
    apply(8'h04, 1, "tog_p2");
    apply(8'h00, 1, "tog_r2");

    apply(8'h02, 2, "last_1");
    apply(8'h22, 2, "last_5");
    apply(8'h02, 2, "last_r5");
    apply(8'h4A, 2, "last_36");
    apply(8'h00, 2, "last_off");

    apply(8'h50, 3, "low_46");
    apply(8'h40, 3, "low_r4");
    apply(8'h00, 3, "low_off");

    for (int i = 0; i < 20; i++)
      apply(int'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : mdl_mode, "rand");
    apply(8'h00, 0, "rand_end");
    check("rand_overrun", overrun, 0);

    event_ready = 1'b0;
    model_apply(8'h89, 0);
    sw = 8'h89;
    cyc(15);
    check("q_valid", event_valid, 1);
    check("q_key0", event_key, 0);
    check("q_press", event_press, 1);
    cyc(5);
    check("q_hold", event_key, 0);
    event_ready = 1'b1;
    cyc(1);
    check("q_key3", event_key, 3);
    cyc(1);
    check("q_key7", event_key, 7);
    check("q_valid7", event_valid, 1);
    cyc(1);
    check("q_empty", event_valid, 0);
    event_ready = 1'b0;
    check("q_en", en, 8'h89);
    compare_events("q");
    apply(8'h00, 1, "q_rel");

    hold_noready(8'h08);
    check("ovr_en", en, 8'h08);
    check("ovr_none0", overrun, 0);
    hold_noready(8'h00);
    hold_noready(8'h08);
    check("ovr_none1", overrun, 0);
    hold_noready(8'h00);
    check("ovr_set", overrun, 1);
    hold_noready(8'h20);
    check("ovr_latch_en", en, mdl_en);
    check("ovr_valid", event_valid, 1);

    #2;
    reset_n = 1'b0;
    #1;
    check("arst_en", en, 0);
    check("arst_valid", event_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_key", event_key, 0);
    sw = 8'h00;
    model_reset();
    @(posedge clk); #1;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    apply(8'h11, 1, "post_p");
    apply(8'h00, 1, "post_r");
    check("post_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
